// File: rtl/i2c_config_seq.sv
// i2c_config_seq: walks a register table and drives the I2C write engine GO/END_OK handshake
module i2c_config_seq #(
  parameter int NUM_ENTRIES = 16,
  parameter int GO_HOLD = 2,
  parameter int GAP = 4,
  parameter int MAX_RETRY = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic        PT_CK,
  input  logic        RESET,
  input  logic        START,
  output logic [7:0]  TBL_ADDR,
  input  logic [23:0] TBL_DATA,
  output logic        GO,
  output logic [7:0]  SLAVE_ADDRESS,
  output logic [15:0] REG_DATA,
  output logic [7:0]  BYTE_NUM,
  input  logic        END_OK,
  input  logic        ACK_OK,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [7:0]  ERR_CNT,
  output logic [7:0]  ERR_IDX
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = TW > 16 ? TW : 16;
  localparam logic [7:0] LAST = 8'(NUM_ENTRIES - 1);
  typedef enum logic [3:0] {IDLE, FETCH, LATCH, ISSUE, WAIT_LO, WAIT_HI, CHECK, DELAY, GAP_W, DONE_ST} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] retry, retry_n;
  logic [7:0] addr_n, sa_n, err_cnt_n, err_idx_n;
  logic [15:0] rd_n;
  logic go_n, busy_n, done_n, err_n, abort, finish;
  assign BYTE_NUM = 8'd2;
  // state and registered outputs; one counter serves GO hold, timeout, delay and gap
  always_ff @(posedge PT_CK) begin
    if (RESET) begin
      state <= IDLE;
      cnt <= '0;
      retry <= '0;
      TBL_ADDR <= '0;
      GO <= 1'b0;
      SLAVE_ADDRESS <= '0;
      REG_DATA <= '0;
      BUSY <= 1'b0;
      DONE <= 1'b0;
      ERR <= 1'b0;
      ERR_CNT <= '0;
      ERR_IDX <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      retry <= retry_n;
      TBL_ADDR <= addr_n;
      GO <= go_n;
      SLAVE_ADDRESS <= sa_n;
      REG_DATA <= rd_n;
      BUSY <= busy_n;
      DONE <= done_n;
      ERR <= err_n;
      ERR_CNT <= err_cnt_n;
      ERR_IDX <= err_idx_n;
    end
  end
  // next state: table walk, write handshake with retry/timeout, local delays
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    retry_n = retry;
    addr_n = TBL_ADDR;
    go_n = GO;
    sa_n = SLAVE_ADDRESS;
    rd_n = REG_DATA;
    busy_n = BUSY;
    done_n = DONE;
    err_n = ERR;
    err_cnt_n = ERR_CNT;
    err_idx_n = ERR_IDX;
    abort = 1'b0;
    finish = 1'b0;
    case (state)
      IDLE, DONE_ST: if (START) begin
        done_n = 1'b0;
        err_n = 1'b0;
        err_cnt_n = '0;
        err_idx_n = '0;
        busy_n = 1'b1;
        addr_n = '0;
        retry_n = '0;
        state_n = FETCH;
      end
      FETCH: state_n = LATCH;
      LATCH: if (TBL_DATA[23:16] == 8'hFF) begin
        cnt_n = CW'(TBL_DATA[15:0]);
        state_n = TBL_DATA[15:0] == 16'd0 ? GAP_W : DELAY;
      end else begin
        sa_n = TBL_DATA[23:16];
        rd_n = TBL_DATA[15:0];
        go_n = 1'b1;
        cnt_n = '0;
        state_n = ISSUE;
      end
      ISSUE: if (cnt == CW'(GO_HOLD - 1)) begin
        go_n = 1'b0;
        cnt_n = '0;
        state_n = WAIT_LO;
      end else cnt_n = cnt + 1'b1;
      WAIT_LO, WAIT_HI: begin
        cnt_n = cnt + 1'b1;
        if (state == WAIT_LO && !END_OK) state_n = WAIT_HI;
        else if (state == WAIT_HI && END_OK) state_n = CHECK;
        else abort = cnt == CW'(TIMEOUT - 1);
      end
      CHECK: if (!ACK_OK) begin
        retry_n = '0;
        cnt_n = '0;
        state_n = GAP_W;
      end else begin
        err_cnt_n = ERR_CNT == 8'hFF ? ERR_CNT : ERR_CNT + 8'd1;
        if (retry < 3'(MAX_RETRY)) begin
          retry_n = retry + 3'd1;
          state_n = LATCH;
        end else abort = 1'b1;
      end
      DELAY: if (cnt == CW'(1)) begin
        cnt_n = '0;
        state_n = GAP_W;
      end else cnt_n = cnt - 1'b1;
      GAP_W: if (cnt == CW'(GAP - 1)) begin
        cnt_n = '0;
        finish = TBL_ADDR == LAST;
        addr_n = TBL_ADDR == LAST ? TBL_ADDR : TBL_ADDR + 8'd1;
        state_n = FETCH;
      end else cnt_n = cnt + 1'b1;
      default: state_n = IDLE;
    endcase
    if (abort || finish) begin
      busy_n = 1'b0;
      done_n = 1'b1;
      state_n = DONE_ST;
    end
    if (abort) begin
      err_n = 1'b1;
      err_idx_n = TBL_ADDR;
    end
  end
endmodule

// File: tb/tb_i2c_config_seq.sv
// tb_i2c_config_seq: directed checks of the table sequencer against a small ROM and write-engine model
module tb_i2c_config_seq;
  localparam int TO = 64;
  logic PT_CK = 1'b0, RESET = 1'b1, START = 1'b0;
  logic [7:0] TBL_ADDR, SLAVE_ADDRESS, BYTE_NUM, ERR_CNT, ERR_IDX;
  logic [23:0] TBL_DATA = '0;
  logic [15:0] REG_DATA;
  logic GO, BUSY, DONE, ERR;
  logic END_OK = 1'b1, ACK_OK = 1'b0;
  logic [23:0] rom [0:255];
  logic plan [0:31];
  logic stuck = 1'b0;
  logic go_d = 1'b0, act = 1'b0;
  int hl = 0, xfer = 0;
  logic [4:0] xfer_no = '0;
  logic [7:0] sa_q[$];
  logic [15:0] rd_q[$];
  int len_q[$];
  int checks = 0, errors = 0, base = 0, gh = 0;
  logic [15:0] exp2 [0:4] = '{16'h1234, 16'hABCD, 16'hABCD, 16'hABCD, 16'h0001};

  i2c_config_seq #(.NUM_ENTRIES(3), .GO_HOLD(2), .GAP(4), .MAX_RETRY(2), .TIMEOUT(TO)) dut (
    .PT_CK(PT_CK), .RESET(RESET), .START(START), .TBL_ADDR(TBL_ADDR), .TBL_DATA(TBL_DATA),
    .GO(GO), .SLAVE_ADDRESS(SLAVE_ADDRESS), .REG_DATA(REG_DATA), .BYTE_NUM(BYTE_NUM),
    .END_OK(END_OK), .ACK_OK(ACK_OK), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .ERR_CNT(ERR_CNT), .ERR_IDX(ERR_IDX)
  );

  always #5 PT_CK = ~PT_CK;

  // registered table ROM, one cycle read latency
  always @(posedge PT_CK) TBL_DATA <= rom[TBL_ADDR];

  // write engine: logs each GO pulse, launches on GO falling, returns ACK_OK from the plan
  always @(posedge PT_CK) begin
    if (RESET) begin
      go_d <= 1'b0;
      hl <= 0;
      act <= 1'b0;
      xfer <= 0;
      xfer_no <= '0;
      END_OK <= 1'b1;
      ACK_OK <= 1'b0;
      sa_q.delete();
      rd_q.delete();
      len_q.delete();
    end else begin
      go_d <= GO;
      if (GO && !go_d) begin
        sa_q.push_back(SLAVE_ADDRESS);
        rd_q.push_back(REG_DATA);
        hl <= 1;
      end else if (GO) hl <= hl + 1;
      if (!GO && go_d) begin
        len_q.push_back(hl);
        if (!stuck) begin
          act <= 1'b1;
          xfer <= 4;
          END_OK <= 1'b0;
        end
      end else if (act) begin
        if (xfer == 0) begin
          act <= 1'b0;
          END_OK <= 1'b1;
          ACK_OK <= plan[xfer_no];
          xfer_no <= xfer_no + 5'd1;
        end else xfer <= xfer - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 600 && !DONE; i++) @(negedge PT_CK);
    chk(tag, DONE, 1);
  endtask

  task automatic kick();
    START = 1'b1;
    @(negedge PT_CK);
    START = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = '0;
    for (int i = 0; i < 32; i++) plan[i] = 1'b0;
    rom[0] = 24'h5A1234;
    rom[1] = 24'h5AABCD;
    rom[2] = 24'h5A0001;
    for (int i = 3; i < 6; i++) plan[i] = 1'b1;
    plan[7] = 1'b1;
    plan[8] = 1'b1;
    repeat (3) @(negedge PT_CK);
    chk("rst_flags", {GO, BUSY, DONE, ERR}, 0);
    chk("rst_regs", {ERR_CNT, ERR_IDX, TBL_ADDR}, 0);
    chk("rst_bnum", BYTE_NUM, 2);
    RESET = 1'b0;
    @(negedge PT_CK);
    // three ACKed writes; first-GO timing from START
    kick();
    chk("t1_start", {BUSY, TBL_ADDR, GO}, {1'b1, 8'd0, 1'b0});
    @(negedge PT_CK);
    chk("t1_fetch_go", GO, 0);
    @(negedge PT_CK);
    chk("t1_go_rise", {GO, SLAVE_ADDRESS, REG_DATA}, {1'b1, 8'h5A, 16'h1234});
    @(negedge PT_CK);
    chk("t1_go_hold", GO, 1);
    @(negedge PT_CK);
    chk("t1_go_fall", GO, 0);
    wait_done("t1_done");
    chk("t1_flags", {ERR, BUSY, ERR_CNT, TBL_ADDR}, {1'b0, 1'b0, 8'd0, 8'd2});
    chk("t1_nwr", sa_q.size(), 3);
    for (int i = 0; i < 3; i++) chk("t1_wr", {sa_q[i], rd_q[i], 8'(len_q[i])}, {rom[i], 8'd2});
    // entry 0 always NACKs, restarted from DONE
    base = sa_q.size();
    kick();
    chk("t3_restart", {DONE, BUSY}, {1'b0, 1'b1});
    wait_done("t3_done");
    chk("t3_err", {ERR, BUSY, ERR_IDX, ERR_CNT}, {1'b1, 1'b0, 8'd0, 8'd3});
    chk("t3_nwr", sa_q.size() - base, 3);
    for (int i = 0; i < 3; i++) chk("t3_wr", rd_q[base + i], 16'h1234);
    // entry 1 NACKs twice then ACKs; START while busy is ignored
    base = sa_q.size();
    kick();
    chk("t2_clear", {DONE, ERR, ERR_CNT}, 0);
    for (int i = 0; i < 300 && TBL_ADDR != 8'd1; i++) @(negedge PT_CK);
    kick();
    chk("t2_ignore", {BUSY, TBL_ADDR}, {1'b1, 8'd1});
    wait_done("t2_done");
    chk("t2_flags", {ERR, ERR_CNT}, {1'b0, 8'd2});
    chk("t2_nwr", sa_q.size() - base, 5);
    for (int i = 0; i < 5; i++) chk("t2_wr", rd_q[base + i], exp2[i]);
    // engine never starts: timeout exactly TO cycles after GO falls
    RESET = 1'b1;
    stuck = 1'b1;
    @(negedge PT_CK);
    RESET = 1'b0;
    kick();
    repeat (3) @(negedge PT_CK);
    chk("t4_go_hi", GO, 1);
    @(negedge PT_CK);
    chk("t4_go_lo", GO, 0);
    repeat (TO - 1) @(negedge PT_CK);
    chk("t4_pre", ERR, 0);
    @(negedge PT_CK);
    chk("t4_err", {ERR, BUSY, DONE, ERR_IDX}, {1'b1, 1'b0, 1'b1, 8'd0});
    stuck = 1'b0;
    // local delay entry of 16 cycles ahead of one write
    RESET = 1'b1;
    rom[0] = 24'hFF0010;
    rom[1] = 24'h3000FF;
    rom[2] = 24'h300001;
    @(negedge PT_CK);
    RESET = 1'b0;
    kick();
    gh = int'(GO);
    for (int i = 0; i < 23; i++) begin
      @(negedge PT_CK);
      gh += int'(GO);
    end
    chk("t5_quiet", gh, 0);
    @(negedge PT_CK);
    chk("t5_go", {GO, SLAVE_ADDRESS, REG_DATA}, {1'b1, 8'h30, 16'h00FF});
    wait_done("t5_done");
    chk("t5_flags", {ERR, 8'(sa_q.size())}, {1'b0, 8'd2});
    // reset during WAIT_HI of entry 1, then a clean rerun
    RESET = 1'b1;
    rom[0] = 24'h5A1234;
    rom[1] = 24'h5AABCD;
    rom[2] = 24'h5A0001;
    plan[0] = 1'b1;
    @(negedge PT_CK);
    RESET = 1'b0;
    kick();
    for (int i = 0; i < 300 && !(TBL_ADDR == 8'd1 && !END_OK); i++) @(negedge PT_CK);
    chk("t6_reach", {TBL_ADDR, END_OK, ERR_CNT}, {8'd1, 1'b0, 8'd1});
    @(negedge PT_CK);
    RESET = 1'b1;
    @(negedge PT_CK);
    chk("t6_rst", {GO, BUSY, DONE, ERR_CNT, TBL_ADDR}, 0);
    plan[0] = 1'b0;
    RESET = 1'b0;
    kick();
    wait_done("t6_done");
    chk("t6_nwr", sa_q.size(), 3);
    chk("t6_first", {sa_q[0], rd_q[0]}, 24'h5A1234);
    chk("t6_flags", {ERR, ERR_CNT}, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_config_seq.md
# i2c_config_seq

Register-table sequencer that sits directly upstream of the I2C write engine. On a start request it walks a table of register writes and presents each entry's slave address and 16-bit data to the engine. For every entry it runs the engine's GO/END_OK handshake, checks the engine's ACK_OK flag, and retries or aborts on NACK or timeout. Table entries whose slave address is 8'hFF are local delays rather than bus writes, which covers power-up waits in device init sequences.

## Interface
Parameters:
- NUM_ENTRIES, 16: table entries walked per run (1..256).
- GO_HOLD, 2: cycles GO is held high per write (>=1).
- GAP, 4: idle cycles after each completed write or delay entry (>=1).
- MAX_RETRY, 2: re-issues of a NACKed entry before aborting (0..7).
- TIMEOUT, 4096: PT_CK cycles allowed from GO falling to END_OK returning high.

Ports:
- PT_CK, in, 1: the single clock, shared with the write engine.
- RESET, in, 1: synchronous, active-high reset, shared with the write engine.
- START, in, 1: run request, sampled in IDLE or DONE.
- TBL_ADDR, out, 8: table read address.
- TBL_DATA, in, 24: table word {slave_addr[23:16], reg_data[15:0]}. Registered ROM with 1-cycle read latency.
- GO, out, 1: write request to the engine.
- SLAVE_ADDRESS, out, 8: slave address to the engine.
- REG_DATA, out, 16: register data to the engine.
- BYTE_NUM, out, 8: constant 8'd2.
- END_OK, in, 1: engine idle flag. High means idle; low means a transfer is in progress.
- ACK_OK, in, 1: engine NACK flag. 1 at END_OK rise means a NACK was seen.
- BUSY, out, 1: run in progress.
- DONE, out, 1: run finished, held until the next START.
- ERR, out, 1: the run aborted on NACK or timeout.
- ERR_CNT, out, 8: total NACKs seen this run, including retried ones; saturates at 255.
- ERR_IDX, out, 8: table index of the aborting entry.

## Operation
- Reset values: all outputs 0 except BYTE_NUM=2, TBL_ADDR=0, and the state register, which goes to IDLE.
- IDLE: on START, clear DONE, ERR, ERR_CNT and ERR_IDX; set BUSY=1, TBL_ADDR=0, retry count=0; go to FETCH.
- FETCH: a single wait cycle for the ROM; go to LATCH.
- LATCH: capture TBL_DATA.
  - If the slave address is 8'hFF, go to DELAY with the counter loaded from reg_data.
  - Otherwise drive SLAVE_ADDRESS and REG_DATA, set GO=1, and go to ISSUE.
- ISSUE: hold GO high for GO_HOLD cycles total, then GO=0, clear the timeout counter, and go to WAIT_LO.
- WAIT_LO: wait for END_OK==0, then go to WAIT_HI.
- WAIT_HI: wait for END_OK==1, then go to CHECK.
- Timeout rule: the timeout counter runs through WAIT_LO and WAIT_HI. On reaching TIMEOUT, set ERR=1, ERR_IDX=TBL_ADDR, and go to DONE_ST.
- CHECK: sample ACK_OK.
  - If 0: clear the retry count and go to GAP.
  - If 1: increment ERR_CNT (saturating). If retry count < MAX_RETRY, increment it and go to LATCH; this re-issues the same entry with TBL_DATA unchanged and no re-fetch. Otherwise set ERR=1, ERR_IDX=TBL_ADDR, and go to DONE_ST.
- DELAY: count reg_data cycles down to 0, then go to GAP. reg_data=0 means no wait.
- GAP: idle for GAP cycles.
  - If TBL_ADDR==NUM_ENTRIES-1, go to DONE_ST.
  - Otherwise increment TBL_ADDR and go to FETCH.
- DONE_ST: BUSY=0, DONE=1. On START, restart exactly as from IDLE.
- START is ignored while BUSY=1.
- GO is never high outside ISSUE.
- SLAVE_ADDRESS and REG_DATA are stable from LATCH until the next LATCH.

## Timing
- START high at edge k: after edge k, BUSY=1 and TBL_ADDR=0. After edge k+2, GO=1 with the entry-0 address and data valid. GO falls after edge k+2+GO_HOLD.
- The engine needs GO high to leave its post-reset idle and GO low to launch. The sequencer relies on this, so a single GO pulse per write is sufficient. GO high into an already-idle engine is harmless.
- Minimum cycles per write entry: 2 (FETCH, LATCH) + GO_HOLD + engine transfer + 1 (CHECK) + GAP.
- Re-issue after NACK: GO rises 1 cycle after CHECK.
- RESET mid-run, including mid-transfer: GO=0 and IDLE after that edge. The engine shares RESET, so no partial handshake survives.
- TBL_ADDR wraps only by design limit. NUM_ENTRIES=256 ends on index 255, never 0.

## Test plan
- 3-entry table {0x5A/0x1234, 0x5A/0xABCD, 0x5A/0x0001} with an engine model that always ACKs (ACK_OK=0) -> three GO pulses with matching SLAVE_ADDRESS and REG_DATA; DONE=1, ERR=0, ERR_CNT=0.
- Entry 1 NACKs twice, then ACKs, with MAX_RETRY=2 -> entry 1 issued 3 times; DONE=1, ERR=0, ERR_CNT=2.
- Entry 0 always NACKs, with MAX_RETRY=2 -> 3 issues; ERR=1, ERR_IDX=0, ERR_CNT=3; entry 1 is never issued.
- Engine holds END_OK=1 forever (never starts) -> ERR=1 exactly TIMEOUT cycles after GO falls; ERR_IDX=0; BUSY=0.
- Table {0xFF/0x0010, 0x30/0x00FF} -> no GO for 16 cycles plus GAP, then one write to 0x30; DONE=1.
- RESET asserted during WAIT_HI of entry 1 -> GO=0, BUSY=0, DONE=0, ERR_CNT=0 next cycle. A following START re-runs from entry 0.
